// File: rtl/trans_stage_multi_pkg.sv
// Shared definitions for the multi-lane pipeline stage latch.
// Holds the stage mode encodings used by the top and by each lane register.
// It also holds the mode decoder that turns flush and stall bits into a mode.
package trans_stage_multi_pkg;

    // Stage behaviour for one clock edge
    typedef enum logic [1:0] {
        STAGE_CAPTURE = 2'b00,
        STAGE_HOLD    = 2'b01,
        STAGE_BUBBLE  = 2'b10
    } stage_mode_e;

    // Priority: flush, then a stall whose successor is running (bubble), then a stall chain (hold)
    function automatic stage_mode_e decode_mode(
        input logic flush,
        input logic stall_self,
        input logic stall_next
    );
        stage_mode_e mode;
        mode = STAGE_CAPTURE;
        if (flush || (stall_self && !stall_next)) begin
            mode = STAGE_BUBBLE;
        end else if (stall_self) begin
            mode = STAGE_HOLD;
        end
        return mode;
    endfunction

endpackage

// File: rtl/trans_stage_multi_if.sv
// Bundle of register-write channels that cross one pipeline stage boundary.
//   in_we/in_addr/in_data    : per-lane write request from the upstream stage
//   out_we/out_addr/out_data : registered per-lane write toward the downstream stage
//   out_valid                : the register holds a captured bundle, not a bubble
//   collision                : the last capture dropped a lane because of an address clash
// Lane i uses bit i of the enables and the slices [i*W +: W] of the address and data buses.
interface trans_stage_multi_if #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic [LANES-1:0]        in_we;
    logic [LANES*ADDR_W-1:0] in_addr;
    logic [LANES*DATA_W-1:0] in_data;
    logic [LANES-1:0]        out_we;
    logic [LANES*ADDR_W-1:0] out_addr;
    logic [LANES*DATA_W-1:0] out_data;
    logic                    out_valid;
    logic                    collision;

    // Upstream producer and downstream consumer side
    modport master (
        output in_we, in_addr, in_data,
        input  out_we, out_addr, out_data, out_valid, collision
    );

    // Stage register side
    modport slave (
        input  in_we, in_addr, in_data,
        output out_we, out_addr, out_data, out_valid, collision
    );
endinterface

// File: rtl/trans_stage_multi_lane.sv
// One write channel of the stage latch: a we/addr/data register.
//   clock, reset      : clock and async active-low reset
//   mode_i            : capture / hold / bubble for this edge
//   kill_i            : clear the captured enable (zero-register drop or lost collision)
//   we_i/addr_i/data_i: incoming write request
//   we_o/addr_o/data_o: registered write request
module trans_lane_reg
    import trans_stage_multi_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  stage_mode_e       mode_i,
    input  logic              kill_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o
);

    logic              we_q,   we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Next-state select; address and data are captured unmodified even when the enable is killed
    always_comb begin
        we_d   = we_q;
        addr_d = addr_q;
        data_d = data_q;
        case (mode_i)
            STAGE_CAPTURE: begin
                we_d   = we_i & ~kill_i;
                addr_d = addr_i;
                data_d = data_i;
            end
            STAGE_BUBBLE: begin
                we_d   = 1'b0;
                addr_d = '0;
                data_d = '0;
            end
            default: begin
            end
        endcase
    end

    // Lane register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign we_o   = we_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/trans_stage_multi.sv
// Multi-lane pipeline stage latch between two stages (EX/MEM, MEM/WB, dual-issue WB).
//   clock, reset      : clock and async active-low reset
//   stall             : shared stall vector; bits STAGE and STAGE+1 select this stage's mode
//   flush             : load a bubble on the next edge regardless of stall
//   perf_clear        : synchronous clear of both performance counters
//   bus (slave)       : per-lane write channels in, registered channels, valid and collision out
//   bubble_count      : saturating count of bubble edges
//   hold_count        : saturating count of hold edges
module trans_stage_multi
    import trans_stage_multi_pkg::*;
#(
    parameter int unsigned LANES     = 2,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned STALL_W   = 6,
    parameter int unsigned STAGE     = 4,
    parameter int unsigned DROP_ZERO = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               perf_clear,
    trans_stage_multi_if.slave bus,
    output logic [CNT_W-1:0]   bubble_count,
    output logic [CNT_W-1:0]   hold_count
);

    stage_mode_e mode_c;
    logic        unused_stall_c;

    logic [LANES-1:0] live_c;
    logic [LANES-1:0] kill_c;
    logic             coll_c;

    logic             valid_q, valid_d;
    logic             coll_q,  coll_d;
    logic [CNT_W-1:0] bub_cnt_q, bub_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [LANES-1:0]        lane_we;
    logic [LANES*ADDR_W-1:0] lane_addr;
    logic [LANES*DATA_W-1:0] lane_data;

    assign mode_c = decode_mode(flush, stall[STAGE], stall[STAGE+1]);

    // Only two stall bits matter to this stage; the rest belong to other boundaries
    assign unused_stall_c = ^stall;

    // Zero-register drop, then same-address resolution where the youngest lane wins
    always_comb begin
        live_c = '0;
        kill_c = '0;
        coll_c = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            live_c[i] = bus.in_we[i] &&
                        !((DROP_ZERO != 0) && (bus.in_addr[i*ADDR_W +: ADDR_W] == '0));
        end
        for (int i = 0; i < LANES; i++) begin
            kill_c[i] = !live_c[i];
            for (int j = i + 1; j < LANES; j++) begin
                if (live_c[i] && live_c[j] &&
                    (bus.in_addr[i*ADDR_W +: ADDR_W] == bus.in_addr[j*ADDR_W +: ADDR_W])) begin
                    kill_c[i] = 1'b1;
                    coll_c    = 1'b1;
                end
            end
        end
    end

    // Bundle status and saturating performance counters
    always_comb begin
        valid_d    = valid_q;
        coll_d     = coll_q;
        bub_cnt_d  = bub_cnt_q;
        hold_cnt_d = hold_cnt_q;
        case (mode_c)
            STAGE_CAPTURE: begin
                valid_d = 1'b1;
                coll_d  = coll_c;
            end
            STAGE_BUBBLE: begin
                valid_d = 1'b0;
                coll_d  = 1'b0;
                if (bub_cnt_q != '1) begin
                    bub_cnt_d = bub_cnt_q + CNT_W'(1);
                end
            end
            STAGE_HOLD: begin
                if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
        if (perf_clear) begin
            bub_cnt_d  = '0;
            hold_cnt_d = '0;
        end
    end

    // Status and counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            coll_q     <= 1'b0;
            bub_cnt_q  <= '0;
            hold_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            coll_q     <= coll_d;
            bub_cnt_q  <= bub_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // One register per write channel
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        trans_lane_reg #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_lane (
            .clock  (clock),
            .reset  (reset),
            .mode_i (mode_c),
            .kill_i (kill_c[g]),
            .we_i   (bus.in_we[g]),
            .addr_i (bus.in_addr[g*ADDR_W +: ADDR_W]),
            .data_i (bus.in_data[g*DATA_W +: DATA_W]),
            .we_o   (lane_we[g]),
            .addr_o (lane_addr[g*ADDR_W +: ADDR_W]),
            .data_o (lane_data[g*DATA_W +: DATA_W])
        );
    end

    assign bus.out_we    = lane_we;
    assign bus.out_addr  = lane_addr;
    assign bus.out_data  = lane_data;
    assign bus.out_valid = valid_q;
    assign bus.collision = coll_q;
    assign bubble_count  = bub_cnt_q;
    assign hold_count    = hold_cnt_q;

endmodule

// File: tb/tb_trans_stage_multi.sv
// Bench for trans_stage_multi: two instances share one stimulus stream.
// dut_a keeps zero-register drop on and uses 16-bit counters.
// dut_b turns zero-register drop off and uses 4-bit counters, so the counters saturate quickly.
module tb_trans_stage_multi;

    localparam int unsigned LANES   = 2;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STALL_W = 6;
    localparam int unsigned STAGE   = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic [STALL_W-1:0] stall = '0;
    logic               flush = 1'b0;
    logic               perf_clear = 1'b0;
    logic [15:0]        bcnt_a, hcnt_a;
    logic [3:0]         bcnt_b, hcnt_b;

    trans_stage_multi_if #(.LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifa ();
    trans_stage_multi_if #(.LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifb ();

    trans_stage_multi #(
        .LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STALL_W(STALL_W),
        .STAGE(STAGE), .DROP_ZERO(1), .CNT_W(16)
    ) dut_a (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .perf_clear(perf_clear), .bus(ifa), .bubble_count(bcnt_a), .hold_count(hcnt_a)
    );

    trans_stage_multi #(
        .LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STALL_W(STALL_W),
        .STAGE(STAGE), .DROP_ZERO(0), .CNT_W(4)
    ) dut_b (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .perf_clear(perf_clear), .bus(ifb), .bubble_count(bcnt_b), .hold_count(hcnt_b)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus for the next edge
    logic [STALL_W-1:0] s_stall;
    logic               s_flush, s_clr;
    logic [LANES-1:0]   s_we;
    logic [ADDR_W-1:0]  s_addr [LANES];
    logic [DATA_W-1:0]  s_data [LANES];

    // Reference model state, one entry per instance
    int          dz   [2] = '{1, 0};
    int          cmax [2] = '{65535, 15};
    bit          m_we   [2][LANES];
    logic [ADDR_W-1:0] m_addr [2][LANES];
    logic [DATA_W-1:0] m_data [2][LANES];
    bit          m_valid [2];
    bit          m_coll  [2];
    int          m_b [2];
    int          m_h [2];

    typedef struct {
        logic [STALL_W-1:0] stall;
        logic               flush;
        logic               clr;
        logic [LANES-1:0]   we;
        logic [ADDR_W-1:0]  a0, a1;
        logic [DATA_W-1:0]  d0, d1;
        logic [LANES-1:0]   e_we;
        logic               e_valid;
        logic               e_coll;
        logic [ADDR_W-1:0]  e_a0;
        logic [DATA_W-1:0]  e_d0;
        int                 e_b;
        int                 e_h;
    } vec_t;

    vec_t vecs [12];

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < LANES; i++) begin
                m_we[d][i]   = 1'b0;
                m_addr[d][i] = '0;
                m_data[d][i] = '0;
            end
            m_valid[d] = 1'b0;
            m_coll[d]  = 1'b0;
            m_b[d]     = 0;
            m_h[d]     = 0;
        end
    endtask

    // Behavioural view: lanes scanned youngest first, an address already claimed loses
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            bit bub, hold;
            int taken [$];
            bub  = s_flush || (s_stall[STAGE] && !s_stall[STAGE+1]);
            hold = !bub && s_stall[STAGE];
            if (bub) begin
                for (int i = 0; i < LANES; i++) begin
                    m_we[d][i] = 1'b0; m_addr[d][i] = '0; m_data[d][i] = '0;
                end
                m_valid[d] = 1'b0;
                m_coll[d]  = 1'b0;
            end else if (!hold) begin
                taken = {};
                m_valid[d] = 1'b1;
                m_coll[d]  = 1'b0;
                for (int i = LANES - 1; i >= 0; i--) begin
                    bit en, seen;
                    en   = s_we[i] && !(dz[d] != 0 && s_addr[i] == 0);
                    seen = 1'b0;
                    foreach (taken[k]) if (taken[k] == int'(s_addr[i])) seen = 1'b1;
                    m_addr[d][i] = s_addr[i];
                    m_data[d][i] = s_data[i];
                    m_we[d][i]   = en && !seen;
                    if (en && seen) m_coll[d] = 1'b1;
                    if (en && !seen) taken.push_back(int'(s_addr[i]));
                end
            end
            if (s_clr) begin
                m_b[d] = 0;
                m_h[d] = 0;
            end else begin
                if (bub && m_b[d] < cmax[d]) m_b[d]++;
                if (hold && m_h[d] < cmax[d]) m_h[d]++;
            end
        end
    endtask

    task automatic check_model();
        for (int d = 0; d < 2; d++) begin
            logic [LANES-1:0]        we;
            logic [LANES*ADDR_W-1:0] ad;
            logic [LANES*DATA_W-1:0] da;
            logic                    v, c;
            logic [63:0]             b, h;
            if (d == 0) begin
                we = ifa.out_we; ad = ifa.out_addr; da = ifa.out_data;
                v = ifa.out_valid; c = ifa.collision; b = 64'(bcnt_a); h = 64'(hcnt_a);
            end else begin
                we = ifb.out_we; ad = ifb.out_addr; da = ifb.out_data;
                v = ifb.out_valid; c = ifb.collision; b = 64'(bcnt_b); h = 64'(hcnt_b);
            end
            for (int i = 0; i < LANES; i++) begin
                cmp($sformatf("dut%0d.out_we[%0d]", d, i), 64'(we[i]), 64'(m_we[d][i]));
                cmp($sformatf("dut%0d.out_addr[%0d]", d, i), 64'(ad[i*ADDR_W +: ADDR_W]), 64'(m_addr[d][i]));
                cmp($sformatf("dut%0d.out_data[%0d]", d, i), 64'(da[i*DATA_W +: DATA_W]), 64'(m_data[d][i]));
            end
            cmp($sformatf("dut%0d.out_valid", d), 64'(v), 64'(m_valid[d]));
            cmp($sformatf("dut%0d.collision", d), 64'(c), 64'(m_coll[d]));
            cmp($sformatf("dut%0d.bubble_count", d), b, 64'(m_b[d]));
            cmp($sformatf("dut%0d.hold_count", d), h, 64'(m_h[d]));
        end
    endtask

    task automatic apply();
        stall      = s_stall;
        flush      = s_flush;
        perf_clear = s_clr;
        for (int i = 0; i < LANES; i++) begin
            ifa.in_we[i] = s_we[i];
            ifb.in_we[i] = s_we[i];
            ifa.in_addr[i*ADDR_W +: ADDR_W] = s_addr[i];
            ifb.in_addr[i*ADDR_W +: ADDR_W] = s_addr[i];
            ifa.in_data[i*DATA_W +: DATA_W] = s_data[i];
            ifb.in_data[i*DATA_W +: DATA_W] = s_data[i];
        end
    endtask

    // Drive, clock one edge, advance the model, sample 1 time unit after the edge
    task automatic step();
        apply();
        @(posedge clock);
        model_step();
        #1;
        check_model();
    endtask

    task automatic set_idle(input logic [STALL_W-1:0] st);
        s_stall = st; s_flush = 1'b0; s_clr = 1'b0; s_we = '0;
        for (int i = 0; i < LANES; i++) begin
            s_addr[i] = '0; s_data[i] = '0;
        end
    endtask

    initial begin
        vecs[0]  = '{6'b000000, 1'b0, 1'b0, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,
                     2'b01, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 0, 0};
        vecs[1]  = '{6'b010000, 1'b0, 1'b0, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,
                     2'b00, 1'b0, 1'b0, 5'd0, 32'h0, 1, 0};
        vecs[2]  = '{6'b110000, 1'b0, 1'b0, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,
                     2'b00, 1'b0, 1'b0, 5'd0, 32'h0, 1, 1};
        vecs[3]  = '{6'b110000, 1'b0, 1'b0, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,
                     2'b00, 1'b0, 1'b0, 5'd0, 32'h0, 1, 2};
        vecs[4]  = '{6'b110000, 1'b0, 1'b0, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,
                     2'b00, 1'b0, 1'b0, 5'd0, 32'h0, 1, 3};
        vecs[5]  = '{6'b000000, 1'b0, 1'b0, 2'b11, 5'd7, 5'd7, 32'h1, 32'h2,
                     2'b10, 1'b1, 1'b1, 5'd7, 32'h1, 1, 3};
        vecs[6]  = '{6'b110000, 1'b0, 1'b0, 2'b01, 5'd1, 5'd2, 32'h9, 32'h9,
                     2'b10, 1'b1, 1'b1, 5'd7, 32'h1, 1, 4};
        vecs[7]  = '{6'b000000, 1'b0, 1'b0, 2'b11, 5'd3, 5'd4, 32'h33, 32'h44,
                     2'b11, 1'b1, 1'b0, 5'd3, 32'h33, 1, 4};
        vecs[8]  = '{6'b000000, 1'b0, 1'b0, 2'b01, 5'd0, 5'd9, 32'h55, 32'h0,
                     2'b00, 1'b1, 1'b0, 5'd0, 32'h55, 1, 4};
        vecs[9]  = '{6'b110000, 1'b1, 1'b0, 2'b11, 5'd3, 5'd3, 32'h1, 32'h1,
                     2'b00, 1'b0, 1'b0, 5'd0, 32'h0, 2, 4};
        vecs[10] = '{6'b000000, 1'b0, 1'b0, 2'b11, 5'd0, 5'd0, 32'h66, 32'h77,
                     2'b00, 1'b1, 1'b0, 5'd0, 32'h66, 2, 4};
        vecs[11] = '{6'b010000, 1'b0, 1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                     2'b00, 1'b0, 1'b0, 5'd0, 32'h0, 0, 0};

        // Reset state
        set_idle('0);
        apply();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_model();
        reset = 1'b1;

        // Directed table against dut_a, with the model covering both instances
        for (int k = 0; k < 12; k++) begin
            s_stall = vecs[k].stall; s_flush = vecs[k].flush; s_clr = vecs[k].clr;
            s_we = vecs[k].we;
            s_addr[0] = vecs[k].a0; s_addr[1] = vecs[k].a1;
            s_data[0] = vecs[k].d0; s_data[1] = vecs[k].d1;
            step();
            cmp($sformatf("vec%0d.out_we", k), 64'(ifa.out_we), 64'(vecs[k].e_we));
            cmp($sformatf("vec%0d.out_valid", k), 64'(ifa.out_valid), 64'(vecs[k].e_valid));
            cmp($sformatf("vec%0d.collision", k), 64'(ifa.collision), 64'(vecs[k].e_coll));
            cmp($sformatf("vec%0d.addr0", k), 64'(ifa.out_addr[ADDR_W-1:0]), 64'(vecs[k].e_a0));
            cmp($sformatf("vec%0d.data0", k), 64'(ifa.out_data[DATA_W-1:0]), 64'(vecs[k].e_d0));
            cmp($sformatf("vec%0d.bubble_count", k), 64'(bcnt_a), 64'(vecs[k].e_b));
            cmp($sformatf("vec%0d.hold_count", k), 64'(hcnt_a), 64'(vecs[k].e_h));
            if (k == 8) cmp("nodrop.out_we", 64'(ifb.out_we), 64'(2'b01));
            if (k == 10) cmp("nodrop.collision", 64'(ifb.collision), 64'(1));
        end

        // Counter saturation on the 4-bit instance, then clear during a bubble
        set_idle(6'b010000);
        repeat (20) step();
        cmp("sat.bubble_count_b", 64'(bcnt_b), 64'(15));
        cmp("sat.bubble_count_a", 64'(bcnt_a), 64'(20));
        s_clr = 1'b1;
        step();
        cmp("clr.bubble_count_a", 64'(bcnt_a), 64'(0));
        cmp("clr.bubble_count_b", 64'(bcnt_b), 64'(0));

        // Asynchronous reset in the middle of a hold
        set_idle('0);
        s_we = 2'b11; s_addr[0] = 5'd1; s_addr[1] = 5'd2;
        s_data[0] = 32'hA5A5A5A5; s_data[1] = 32'h5A5A5A5A;
        step();
        s_stall = 6'b110000;
        step();
        step();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        cmp("rst.out_we", 64'(ifa.out_we), 64'(0));
        cmp("rst.out_data", 64'(ifa.out_data), 64'(0));
        cmp("rst.hold_count", 64'(hcnt_a), 64'(0));
        check_model();
        #1;
        reset = 1'b1;
        step();
        cmp("post_rst.hold_count", 64'(hcnt_a), 64'(1));
        cmp("post_rst.out_valid", 64'(ifa.out_valid), 64'(0));

        // Randomized traffic with small address space to provoke drops and collisions
        for (int n = 0; n < 400; n++) begin
            s_stall = STALL_W'($urandom);
            s_flush = ($urandom_range(0, 7) == 0);
            s_clr   = ($urandom_range(0, 15) == 0);
            s_we    = LANES'($urandom);
            for (int i = 0; i < LANES; i++) begin
                s_addr[i] = ADDR_W'($urandom_range(0, 3));
                s_data[i] = $urandom;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trans_stage_multi.md
Name: trans_stage_multi

Overview:
Parametrised successor to the single-lane stage latch. Registers LANES independent register-write channels (enable/address/data) between two pipeline stages. Decodes its own hold/bubble from the shared stall vector and adds an explicit flush, an output valid flag, same-cycle lane-collision resolution, zero-register drop, and saturating hold/bubble performance counters. One instance is used per stage boundary (EX/MEM, MEM/WB, dual-issue WB) by setting STAGE and LANES.

Parameters:
LANES, 2, number of write channels (1..4)
ADDR_W, 5, register address width
DATA_W, 32, register data width
STALL_W, 6, width of shared stall vector
STAGE, 4, index of this stage's bit in stall; STAGE+1 must be < STALL_W
DROP_ZERO, 1, when 1 a write to address 0 has its enable cleared on capture
CNT_W, 16, width of performance counters

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  STALL_W  shared stall vector, 1 = stall enable
flush  in  1  squash: load a bubble next edge regardless of stall
perf_clear  in  1  synchronous clear of both counters
in_we  in  LANES  per-lane write enable, lane i = bit i
in_addr  in  LANES*ADDR_W  lane i at [i*ADDR_W +: ADDR_W]
in_data  in  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
out_we  out  LANES  registered enables
out_addr  out  LANES*ADDR_W  registered addresses
out_data  out  LANES*DATA_W  registered data
out_valid  out  1  1 = register holds a captured (non-bubble) bundle
collision  out  1  registered, 1 = capture this cycle dropped a lane for collision
bubble_count  out  CNT_W  saturating count of bubble cycles
hold_count  out  CNT_W  saturating count of hold cycles

Behaviour:
- Reset (reset=0, async): all out_* = 0, out_valid=0, collision=0, both counters = 0.
- Mode decode per edge, priority order:
  1. flush=1 -> BUBBLE
  2. stall[STAGE]=1 and stall[STAGE+1]=0 -> BUBBLE
  3. stall[STAGE]=1 and stall[STAGE+1]=1 -> HOLD
  4. stall[STAGE]=0 -> CAPTURE
- BUBBLE: out_we, out_addr, out_data, out_valid and collision all load 0; bubble_count += 1.
- HOLD: all outputs keep their values, including collision; hold_count += 1.
- CAPTURE: out_valid=1; address/data load from inputs unmodified. Per-lane enable = in_we[i], then:
  - DROP_ZERO=1 and in_addr[i]=0 -> enable cleared.
  - Collision: lanes i<j both enabled (after zero-drop) with equal address -> lane i enable cleared; higher-index (younger) lane wins; collision=1.
  - Otherwise collision=0.
- Latency: exactly 1 cycle from input to output in CAPTURE. There is no combinational path from in_* to out_*.
- Counters:
  - Saturate at all-ones; no wrap.
  - perf_clear=1 forces 0 on that edge and overrides the increment.
  - Counters are unaffected by flush except through the BUBBLE increment.
- Reset asserted mid-HOLD or mid-BUBBLE clears immediately; the first edge after release decodes normally.
- LANES=1 with DROP_ZERO=0 and flush tied 0 is cycle-identical to the legacy single-lane latch, plus out_valid and the counters.

Decomposition:
- defines.v already holds RESET_ENABLE/STALL_ENABLE/STALL_DISABLE/WRITE_DISABLE. Add STAGE_CAPTURE, STAGE_HOLD and STAGE_BUBBLE 2-bit mode encodings there so that the top and the sub-module share them.
- Sub-module trans_lane_reg: one lane's we/addr/data flop with a mode input and a kill input (collision/zero-drop). It is instantiated LANES times in a generate loop.
- Collision kill logic, the mode decoder and the counters live in the top.

Test Plan:
- Reset 0 then release; drive lane0 we=1, addr=5, data=0xDEADBEEF with stall=0 -> next edge out_we[0]=1, out_addr lane0=5, out_data lane0=0xDEADBEEF, out_valid=1.
- Capture, then stall=6'b010000 for 1 cycle -> outputs all 0, out_valid=0, bubble_count=1. Then stall=6'b110000 for 3 cycles -> bubble held, hold_count=3.
- Capture lane0 addr=7 data=1 and lane1 addr=7 data=2, both enabled -> out_we=2'b10, collision=1. Next capture with distinct addresses -> collision=0.
- Lane0 we=1 addr=0, DROP_ZERO=1 -> out_we[0]=0, out_valid=1. Repeat with a DROP_ZERO=0 build -> out_we[0]=1.
- flush=1 together with stall=6'b110000 -> BUBBLE wins: outputs 0, bubble_count increments, hold_count unchanged.
- CNT_W=4: 20 consecutive bubbles -> bubble_count=15 and stays there. perf_clear=1 in the same cycle as a bubble -> 0. Assert reset mid-hold -> out_* = 0 immediately, without waiting for a clock edge.
